// File: rtl/pcie_tlp_pkg.sv
// Shared PCIe TLP definitions for the TX path: format/type codes, byte-enable
// constants, the MWr requester state encoding and the DW-slot helper.
package pcie_tlp_pkg;

  // Format/type codes
  localparam logic [2:0] FMT_MWR32 = 3'b010;
  localparam logic [4:0] TYPE_MWR  = 5'b00000;
  localparam logic [2:0] FMT_CPLD  = 3'b010;
  localparam logic [4:0] TYPE_CPLD = 5'b01010;

  // Byte enables
  localparam logic [3:0] BE_ALL  = 4'hF;
  localparam logic [3:0] BE_NONE = 4'h0;

  // TX beat geometry: 8 DW slots per 256-bit beat, 3-DW header
  localparam int TX_SLOTS = 8;
  localparam int HDR_DW   = 3;

  // MWr requester states; IDLE must stay at zero so a reset debug view reads 0
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SPLIT = 3'd1,
    ST_FETCH = 3'd2,
    ST_SEND  = 3'd3,
    ST_DONE  = 3'd4
  } mwr_state_e;

  // MSB bit index of DW slot k within a 256-bit beat (slot 0 is the top DW)
  function automatic int slot_msb(input int k);
    return 255 - 32 * k;
  endfunction

endpackage

// File: rtl/pcie_tlp_hdr_build.sv
// Combinational 3-DW header assembly for 32-bit-address memory-type TLPs.
// Shared so a future MRd requester can reuse it with a different type code.
module pcie_tlp_hdr_build
  import pcie_tlp_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [4:0]  tlp_type,
  input  logic [9:0]  len_dw,
  input  logic [15:0] requester_id,
  input  logic [7:0]  tag,
  input  logic [31:0] addr,
  output logic [31:0] dw0,
  output logic [31:0] dw1,
  output logic [31:0] dw2
);

  logic [3:0] last_be;

  // Build header DWs; single-DW requests must carry a zero LastBE
  always_comb begin
    last_be = (len_dw > 10'd1) ? BE_ALL : BE_NONE;
    dw0     = {fmt, tlp_type, 14'b0, len_dw};
    dw1     = {requester_id, tag, last_be, BE_ALL};
    dw2     = addr & 32'hFFFF_FFFC;
  end

endmodule

// File: rtl/pcie_mwr_tlp_tx.sv
// Requester-side MWr32 TLP generator: splits a local memory span into posted
// TLPs (max payload, never crossing a 4KB host page) and streams them as
// 256-bit beats to the PCIe core TX port, holding each beat while tl_tx_wait.
// Valid/ready: a beat transfers on any cycle where tx_valid != 0 and
// tl_tx_wait == 0; while tl_tx_wait is high every tx_* output holds its value.
module pcie_mwr_tlp_tx
  import pcie_tlp_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH = 16,
  parameter int MAX_PAYLOAD_DW = 32,
  parameter int LEN_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      start,
  input  logic [31:0]               host_addr,
  input  logic [MEM_ADDR_WIDTH-1:0] local_addr,
  input  logic [LEN_WIDTH-1:0]      len_dw,
  input  logic [15:0]               requester_id,
  output logic                      busy,
  output logic                      done,
  output logic                      mem_read_req,
  output logic [MEM_ADDR_WIDTH-1:0] mem_read_addr,
  input  logic [31:0]               mem_read_data,
  input  logic                      tl_tx_wait,
  output logic                      tx_sop,
  output logic                      tx_eop,
  output logic [255:0]              tx_data,
  output logic [7:0]                tx_valid,
  output logic [2:0]                state_dbg
);

  localparam int CW = LEN_WIDTH + 12;

  mwr_state_e state_q, state_d;

  logic [31:0]               haddr_q;
  logic [MEM_ADDR_WIDTH-1:0] laddr_q;
  logic [MEM_ADDR_WIDTH-1:0] rd_addr_q;
  logic [LEN_WIDTH-1:0]      remaining_q;
  logic [7:0]                tag_q;
  logic [15:0]               rid_q;
  logic [9:0]                tlp_len_q;
  logic [9:0]                pay_left_q;
  logic [3:0]                issue_slot_q;
  logic [3:0]                issue_end_q;
  logic                      rd_pend_q;
  logic [2:0]                rd_slot_q;
  logic                      first_beat_q;
  logic [31:0]               beat_buf [TX_SLOTS];

  logic [10:0]          bnd_dw;
  logic [10:0]          cap_dw;
  logic [9:0]           split_len;
  logic [3:0]           first_pay;
  logic [3:0]           next_pay;
  logic                 issue_more;
  logic                 xfer;
  logic                 last_beat;
  logic [LEN_WIDTH-1:0] rem_after;
  logic [31:0]          hdr_dw0, hdr_dw1, hdr_dw2;

  // Split arithmetic: DWs left before the 4KB page ends, capped by max payload and remaining
  always_comb begin
    bnd_dw     = 11'd1024 - {1'b0, haddr_q[11:2]};
    cap_dw     = (bnd_dw < 11'(MAX_PAYLOAD_DW)) ? bnd_dw : 11'(MAX_PAYLOAD_DW);
    split_len  = (CW'(remaining_q) < CW'(cap_dw)) ? remaining_q[9:0] : cap_dw[9:0];
    first_pay  = (split_len > 10'd5) ? 4'd5 : split_len[3:0];
    next_pay   = (pay_left_q > 10'd8) ? 4'd8 : pay_left_q[3:0];
    issue_more = issue_slot_q < issue_end_q;
    xfer       = (state_q == ST_SEND) && !tl_tx_wait;
    last_beat  = (pay_left_q == 10'd0);
    rem_after  = remaining_q - LEN_WIDTH'(tlp_len_q);
  end

  pcie_tlp_hdr_build u_hdr (
    .fmt          (FMT_MWR32),
    .tlp_type     (TYPE_MWR),
    .len_dw       (split_len),
    .requester_id (rid_q),
    .tag          (tag_q),
    .addr         (haddr_q),
    .dw0          (hdr_dw0),
    .dw1          (hdr_dw1),
    .dw2          (hdr_dw2)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state and output decode; tx_* are zero outside SEND so idle slots read 0
  always_comb begin
    state_d       = state_q;
    busy          = (state_q != ST_IDLE) && (state_q != ST_DONE);
    done          = (state_q == ST_DONE);
    mem_read_req  = (state_q == ST_FETCH) && issue_more;
    mem_read_addr = '0;
    tx_sop        = 1'b0;
    tx_eop        = 1'b0;
    tx_valid      = 8'h00;
    tx_data       = '0;
    if (mem_read_req) mem_read_addr = rd_addr_q;
    if (state_q == ST_SEND) begin
      tx_sop   = first_beat_q;
      tx_eop   = last_beat;
      tx_valid = ~(8'hFF >> issue_end_q);
      for (int k = 0; k < TX_SLOTS; k++) tx_data[slot_msb(k) -: 32] = beat_buf[k];
    end
    case (state_q)
      ST_IDLE:  if (start) state_d = (len_dw == '0) ? ST_DONE : ST_SPLIT;
      ST_SPLIT: state_d = ST_FETCH;
      ST_FETCH: if (!issue_more && rd_pend_q) state_d = ST_SEND;
      ST_SEND: begin
        if (xfer) begin
          if (!last_beat)            state_d = ST_FETCH;
          else if (rem_after == '0)  state_d = ST_DONE;
          else                       state_d = ST_SPLIT;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign state_dbg = state_q;

  // Datapath: command latch, beat setup, read issue/capture and per-TLP address advance
  always_ff @(posedge clk) begin
    if (!rstn) begin
      haddr_q      <= '0;
      laddr_q      <= '0;
      rd_addr_q    <= '0;
      remaining_q  <= '0;
      tag_q        <= '0;
      rid_q        <= '0;
      tlp_len_q    <= '0;
      pay_left_q   <= '0;
      issue_slot_q <= '0;
      issue_end_q  <= '0;
      rd_pend_q    <= 1'b0;
      rd_slot_q    <= '0;
      first_beat_q <= 1'b0;
      for (int k = 0; k < TX_SLOTS; k++) beat_buf[k] <= '0;
    end else begin
      rd_pend_q <= mem_read_req;
      rd_slot_q <= issue_slot_q[2:0];
      if (rd_pend_q) beat_buf[rd_slot_q] <= mem_read_data;
      if (mem_read_req) begin
        issue_slot_q <= issue_slot_q + 4'd1;
        rd_addr_q    <= rd_addr_q + MEM_ADDR_WIDTH'(1);
      end
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            haddr_q     <= host_addr & 32'hFFFF_FFFC;
            laddr_q     <= local_addr;
            remaining_q <= len_dw;
            rid_q       <= requester_id;
          end
        end
        ST_SPLIT: begin
          tlp_len_q    <= split_len;
          beat_buf[0]  <= hdr_dw0;
          beat_buf[1]  <= hdr_dw1;
          beat_buf[2]  <= hdr_dw2;
          for (int k = HDR_DW; k < TX_SLOTS; k++) beat_buf[k] <= '0;
          pay_left_q   <= split_len - {6'b0, first_pay};
          issue_slot_q <= 4'(HDR_DW);
          issue_end_q  <= 4'(HDR_DW) + first_pay;
          first_beat_q <= 1'b1;
          rd_addr_q    <= laddr_q;
        end
        ST_SEND: begin
          if (xfer) begin
            if (last_beat) begin
              haddr_q     <= haddr_q + 32'({tlp_len_q, 2'b00});
              laddr_q     <= laddr_q + MEM_ADDR_WIDTH'(tlp_len_q);
              remaining_q <= rem_after;
              tag_q       <= tag_q + 8'd1;
            end else begin
              for (int k = 0; k < TX_SLOTS; k++) beat_buf[k] <= '0;
              pay_left_q   <= pay_left_q - {6'b0, next_pay};
              issue_slot_q <= 4'd0;
              issue_end_q  <= next_pay;
              first_beat_q <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pcie_mwr_tlp_tx.sv
// Bench for pcie_mwr_tlp_tx: directed commands push expected beats into a
// queue; an independent negedge monitor pops and compares every accepted beat.
module tb_pcie_mwr_tlp_tx;
  import pcie_tlp_pkg::*;

  localparam int BW = 266;  // {sop, eop, valid[7:0], data[255:0]}

  logic         clk;
  logic         rstn;
  logic         start;
  logic [31:0]  host_addr;
  logic [15:0]  local_addr;
  logic [15:0]  len_dw;
  logic [15:0]  requester_id;
  logic         busy;
  logic         done;
  logic         mem_read_req;
  logic [15:0]  mem_read_addr;
  logic [31:0]  mem_read_data;
  logic         tl_tx_wait;
  logic         tx_sop;
  logic         tx_eop;
  logic [255:0] tx_data;
  logic [7:0]   tx_valid;
  logic [2:0]   state_dbg;

  logic [BW-1:0] exp_q[$];
  int            n_cmp;
  int            n_bad;
  int            done_seen;
  int            beat_cnt;
  int            cyc;
  int            last_xfer_cyc;
  logic          had_beats;
  logic [7:0]    exp_tag;

  pcie_mwr_tlp_tx #(
    .MEM_ADDR_WIDTH (16),
    .MAX_PAYLOAD_DW (32),
    .LEN_WIDTH      (16)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .start         (start),
    .host_addr     (host_addr),
    .local_addr    (local_addr),
    .len_dw        (len_dw),
    .requester_id  (requester_id),
    .busy          (busy),
    .done          (done),
    .mem_read_req  (mem_read_req),
    .mem_read_addr (mem_read_addr),
    .mem_read_data (mem_read_data),
    .tl_tx_wait    (tl_tx_wait),
    .tx_sop        (tx_sop),
    .tx_eop        (tx_eop),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .state_dbg     (state_dbg)
  );

  // ---------------- clock / memory model ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return {~a, a};
  endfunction

  // Local memory answers exactly one cycle after each read strobe
  always @(posedge clk) mem_read_data <= mem_read_req ? mem_word(mem_read_addr) : 32'h0;

  // ---------------- reference model ----------------
  // Expected beats for a whole command: split the span per TLP, lay header
  // and payload DWs out as one flat stream and cut it into 8-DW beats.
  task automatic model_cmd(input logic [31:0] host, input logic [15:0] loc, input int len);
    logic [31:0]  ha;
    logic [15:0]  la;
    logic [31:0]  dws[$];
    logic [255:0] d;
    logic [7:0]   v;
    int rem, tl, bnd, total, nb, nv;
    ha  = host & 32'hFFFF_FFFC;
    la  = loc;
    rem = len;
    while (rem > 0) begin
      bnd = 1024 - int'(ha[11:2]);
      tl  = rem;
      if (tl > 32)  tl = 32;
      if (tl > bnd) tl = bnd;
      dws.delete();
      dws.push_back(32'h4000_0000 | 32'(tl));
      dws.push_back({requester_id, exp_tag, (tl > 1) ? 4'hF : 4'h0, 4'hF});
      dws.push_back(ha);
      for (int i = 0; i < tl; i++) dws.push_back(mem_word(16'(la + 16'(i))));
      total = 3 + tl;
      nb    = (total + 7) / 8;
      for (int b = 0; b < nb; b++) begin
        d  = '0;
        v  = '0;
        nv = total - 8 * b;
        if (nv > 8) nv = 8;
        for (int s = 0; s < nv; s++) begin
          d[255 - 32 * s -: 32] = dws[8 * b + s];
          v[7 - s] = 1'b1;
        end
        exp_q.push_back({(b == 0), (b == nb - 1), v, d});
      end
      ha      = ha + 32'(4 * tl);
      la      = 16'(la + 16'(tl));
      rem     = rem - tl;
      exp_tag = exp_tag + 8'd1;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic start_cmd(input logic [31:0] host, input logic [15:0] loc, input logic [15:0] len);
    @(negedge clk);
    host_addr  = host;
    local_addr = loc;
    len_dw     = len;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget);
    for (int i = 0; i < budget && done_seen == d0; i++) @(negedge clk);
    n_cmp++;
    if (done_seen == d0) begin
      n_bad++;
      $display("FAIL done_timeout: done pulses seen %0d, required more than %0d within %0d cycles",
               done_seen, d0, budget);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %b, required %b", name, act, req);
    end
  endtask

  task automatic check_zero(input string name);
    logic [290:0] v;
    v = {busy, done, mem_read_req, mem_read_addr, tx_sop, tx_eop, tx_valid, tx_data, state_dbg};
    n_cmp++;
    if (v !== '0) begin
      n_bad++;
      $display("FAIL %s: busy=%b done=%b req=%b addr=%h sop=%b eop=%b valid=%h data=%h state=%0d, required all 0",
               name, busy, done, mem_read_req, mem_read_addr, tx_sop, tx_eop, tx_valid, tx_data, state_dbg);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [BW-1:0] got, exp, snap;
    logic held;
    held = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      got = {tx_sop, tx_eop, tx_valid, tx_data};
      if (!rstn) begin
        held = 1'b0;
      end else begin
        if (tx_valid != 8'h00 && !tl_tx_wait) begin
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_beat: sop=%b eop=%b valid=%h data=%h, required no beat",
                     tx_sop, tx_eop, tx_valid, tx_data);
          end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
              n_bad++;
              $display("FAIL beat: got sop/eop=%b%b valid=%h data=%h, required sop/eop=%b%b valid=%h data=%h",
                       got[265], got[264], got[263:256], got[255:0], exp[265], exp[264], exp[263:256], exp[255:0]);
            end
          end
          last_xfer_cyc = cyc;
          if (tx_eop) beat_cnt = 0;
          else        beat_cnt++;
          held = 1'b0;
        end else if (tx_valid != 8'h00) begin
          if (held) begin
            n_cmp++;
            if (got !== snap) begin
              n_bad++;
              $display("FAIL hold_stable: got valid=%h data=%h, required valid=%h data=%h",
                       got[263:256], got[255:0], snap[263:256], snap[255:0]);
            end
          end else begin
            snap = got;
            held = 1'b1;
          end
        end else begin
          held = 1'b0;
        end
        if (done) begin
          done_seen++;
          n_cmp++;
          if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL done_pending: %0d beats still expected at done, required 0", exp_q.size());
          end
          if (had_beats) begin
            n_cmp++;
            if (cyc != last_xfer_cyc + 1) begin
              n_bad++;
              $display("FAIL done_latency: done %0d cycles after last beat, required 1", cyc - last_xfer_cyc);
            end
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int  d0;
    logic found;
    n_cmp = 0; n_bad = 0; done_seen = 0; beat_cnt = 0; cyc = 0; last_xfer_cyc = 0;
    had_beats = 1'b0; exp_tag = 8'd0;
    rstn = 1'b0; start = 1'b0; host_addr = '0; local_addr = '0; len_dw = '0;
    tl_tx_wait = 1'b0; requester_id = 16'h0100;
    repeat (3) @(negedge clk);
    check_zero("reset_outputs");
    rstn = 1'b1;

    // 1: host 0x1000, local 0, len 3 -> one beat, hand-computed
    exp_q.push_back({1'b1, 1'b1, 8'hFC,
                     32'h4000_0003, 32'h0100_00FF, 32'h0000_1000,
                     32'hFFFF_0000, 32'hFFFE_0001, 32'hFFFD_0002, 32'h0, 32'h0});
    exp_tag = 8'd1;
    had_beats = 1'b1;
    d0 = done_seen;
    start_cmd(32'h0000_1000, 16'h0000, 16'd3);
    check_bit("busy_after_start", busy, 1'b1);
    wait_done(d0, 200);

    // 2: len 40 -> 32 DW TLP then 8 DW TLP at +0x80
    model_cmd(32'h0001_0000, 16'h0010, 40);
    d0 = done_seen;
    start_cmd(32'h0001_0000, 16'h0010, 16'd40);
    wait_done(d0, 400);

    // 3: 4KB line crossing split into 4 DW at 0x1FF0 and 4 DW at 0x2000
    model_cmd(32'h0000_1FF0, 16'h0040, 8);
    d0 = done_seen;
    start_cmd(32'h0000_1FF0, 16'h0040, 16'd8);
    wait_done(d0, 200);

    // 4: back-pressure for 5 cycles on beat 2 of a 32-DW TLP
    model_cmd(32'h0000_2000, 16'h0000, 32);
    d0 = done_seen;
    start_cmd(32'h0000_2000, 16'h0000, 16'd32);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(posedge clk); #1;
      if (tx_valid != 8'h00 && beat_cnt == 2) found = 1'b1;
    end
    check_bit("beat2_seen", found, 1'b1);
    tl_tx_wait = 1'b1;
    repeat (5) @(posedge clk);
    #1 tl_tx_wait = 1'b0;
    wait_done(d0, 300);

    // 5a: len 1 -> LastBE 0, valid F0, hand-computed (tag 6)
    exp_q.push_back({1'b1, 1'b1, 8'hF0,
                     32'h4000_0001, 32'h0100_060F, 32'h0000_3000, 32'hFEFF_0100,
                     32'h0, 32'h0, 32'h0, 32'h0});
    exp_tag = 8'd7;
    d0 = done_seen;
    start_cmd(32'h0000_3000, 16'h0100, 16'd1);
    wait_done(d0, 200);

    // 5b: len 0 -> done on the cycle after start, no beat
    had_beats = 1'b0;
    d0 = done_seen;
    start_cmd(32'h0000_3100, 16'h0100, 16'd0);
    check_bit("len0_done_next_cycle", done, 1'b1);
    wait_done(d0, 10);

    // 6a: a start while busy is ignored
    had_beats = 1'b1;
    model_cmd(32'h0000_4000, 16'h0200, 12);
    d0 = done_seen;
    start_cmd(32'h0000_4000, 16'h0200, 16'd12);
    repeat (2) @(negedge clk);
    start_cmd(32'h0000_7000, 16'h0700, 16'd5);
    wait_done(d0, 200);
    repeat (10) @(negedge clk);

    // 6b: reset in the middle of a TLP
    model_cmd(32'h0000_5000, 16'h0400, 20);
    start_cmd(32'h0000_5000, 16'h0400, 16'd20);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(posedge clk); #1;
      if (tx_valid != 8'h00) found = 1'b1;
    end
    check_bit("midtlp_beat_seen", found, 1'b1);
    rstn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_zero("midtlp_reset_outputs");
    exp_q.delete();
    exp_tag = 8'd0;
    beat_cnt = 0;
    rstn = 1'b1;

    // 6c: fresh command after reset starts again from tag 0
    model_cmd(32'h0000_6000, 16'h0300, 4);
    d0 = done_seen;
    start_cmd(32'h0000_6000, 16'h0300, 16'd4);
    wait_done(d0, 200);

    repeat (5) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL final_queue: %0d beats never seen, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
